// File: rtl/trap_ctrl_pkg.sv
// Shared core types for the commit-side trap sequencer: ROB index with wrap bit,
// age comparison, trap FSM states and RISC-V trap cause codes.
package trap_ctrl_pkg;

    localparam int ROB_IDX_W = 7;
    localparam int ROB_W     = ROB_IDX_W + 1;
    localparam int CAUSE_W   = 16;
    localparam int XLEN      = 64;

    typedef struct packed {
        logic                 flipped;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_FLUSH,
        ST_REDIRECT
    } trap_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        EXC_INST_MISALIGNED  = 16'd0,
        EXC_INST_ACCESS      = 16'd1,
        EXC_ILLEGAL_INST     = 16'd2,
        EXC_BREAKPOINT       = 16'd3,
        EXC_LOAD_MISALIGNED  = 16'd4,
        EXC_LOAD_ACCESS      = 16'd5,
        EXC_STORE_MISALIGNED = 16'd6,
        EXC_STORE_ACCESS     = 16'd7,
        EXC_ECALL_U          = 16'd8,
        EXC_ECALL_S          = 16'd9,
        EXC_ECALL_M          = 16'd11,
        EXC_INST_PAGE_FAULT  = 16'd12,
        EXC_LOAD_PAGE_FAULT  = 16'd13,
        EXC_STORE_PAGE_FAULT = 16'd15
    } rv_trap_exc_t;

    typedef enum logic [CAUSE_W-1:0] {
        IRQ_S_SOFT  = 16'd1,
        IRQ_M_SOFT  = 16'd3,
        IRQ_S_TIMER = 16'd5,
        IRQ_M_TIMER = 16'd7,
        IRQ_S_EXT   = 16'd9,
        IRQ_M_EXT   = 16'd11
    } rv_trap_irq_t;

    // The wrap bit inverts the index order once the ROB pointer has lapped.
    function automatic logic rob_older(robIdx_t a, robIdx_t b);
        return (a.flipped == b.flipped) ? (a.idx < b.idx) : (a.idx > b.idx);
    endfunction

endpackage

// File: rtl/trap_ctrl_age_sel.sv
// trap_age_sel: combinational pick of the oldest valid exception report
// across NUM_REPORT ports; ties on ROB index go to the lowest port.
module trap_age_sel
    import trap_ctrl_pkg::*;
#(
    parameter int NUM_REPORT = 3,
    localparam int PORT_W = (NUM_REPORT > 1) ? $clog2(NUM_REPORT) : 1
) (
    input  logic [NUM_REPORT-1:0]         i_vld,
    input  logic [NUM_REPORT*ROB_W-1:0]   i_robIdx,
    input  logic [NUM_REPORT*CAUSE_W-1:0] i_cause,
    input  logic [NUM_REPORT*XLEN-1:0]    i_tval,
    output logic                          o_vld,
    output logic [PORT_W-1:0]             o_port,
    output logic [ROB_W-1:0]              o_robIdx,
    output logic [CAUSE_W-1:0]            o_cause,
    output logic [XLEN-1:0]               o_tval
);

    robIdx_t            w_rob   [NUM_REPORT];
    logic [CAUSE_W-1:0] w_cause [NUM_REPORT];
    logic [XLEN-1:0]    w_tval  [NUM_REPORT];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REPORT; gi++) begin : g_unpack
            assign w_rob[gi]   = i_robIdx[gi*ROB_W +: ROB_W];
            assign w_cause[gi] = i_cause[gi*CAUSE_W +: CAUSE_W];
            assign w_tval[gi]  = i_tval[gi*XLEN +: XLEN];
        end
    endgenerate

    always_comb begin
        o_vld    = 1'b0;
        o_port   = '0;
        o_robIdx = '0;
        o_cause  = '0;
        o_tval   = '0;
        for (int i = 0; i < NUM_REPORT; i++) begin
            // strictly-older test keeps the earlier (lower) port on equal index
            if (i_vld[i] && (!o_vld || rob_older(w_rob[i], robIdx_t'(o_robIdx)))) begin
                o_vld    = 1'b1;
                o_port   = PORT_W'(i);
                o_robIdx = w_rob[i];
                o_cause  = w_cause[i];
                o_tval   = w_tval[i];
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Commit-side trap sequencer: tracks the oldest live exception, traps it at the
// ROB head (flush, CSR write, redirect). Interrupt path under `TRAP_CTRL_IRQ_EN.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int NUM_REPORT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REPORT-1:0]         i_exc_vld,
    input  logic [NUM_REPORT*ROB_W-1:0]   i_exc_robIdx,
    input  logic [NUM_REPORT*CAUSE_W-1:0] i_exc_cause,
    input  logic [NUM_REPORT*XLEN-1:0]    i_exc_tval,
    input  logic                          i_squash_vld,
    input  logic [ROB_W-1:0]              i_squash_robIdx,
    input  logic                          i_head_vld,
    input  logic [ROB_W-1:0]              i_head_robIdx,
    input  logic [63:0]                   i_head_pc,
    input  logic [63:0]                   i_mtvec,
`ifdef TRAP_CTRL_IRQ_EN
    input  logic                          i_irq_vld,
    input  logic [15:0]                   i_irq_cause,
`endif
    output logic                          o_commit_block,
    output logic                          o_flush,
    output logic                          o_csr_we,
    output logic [63:0]                   o_mepc,
    output logic [63:0]                   o_mcause,
    output logic [63:0]                   o_mtval,
    output logic                          o_redirect_vld,
    output logic [63:0]                   o_redirect_pc,
    input  logic                          i_redirect_rdy
);

    localparam int PORT_W = (NUM_REPORT > 1) ? $clog2(NUM_REPORT) : 1;

    trap_state_e        r_state, w_state_next;
    robIdx_t            r_rec_rob;
    logic [CAUSE_W-1:0] r_rec_cause;
    logic [63:0]        r_rec_tval;
    logic [63:0]        r_mepc;
    logic               r_is_irq;

    logic               w_sel_vld;
    logic [PORT_W-1:0]  w_sel_port;
    logic [ROB_W-1:0]   w_sel_rob_raw;
    logic [CAUSE_W-1:0] w_sel_cause;
    logic [63:0]        w_sel_tval;
    robIdx_t            w_sel_rob, w_squash_rob, w_head_rob;
    logic               w_head_match, w_rec_squashed, w_sel_ok;
    logic               w_irq_take;
    logic [CAUSE_W-1:0] w_irq_cause;
    logic [63:0]        w_vector;

    trap_age_sel #(.NUM_REPORT(NUM_REPORT)) u_age_sel (
        .i_vld    (i_exc_vld),
        .i_robIdx (i_exc_robIdx),
        .i_cause  (i_exc_cause),
        .i_tval   (i_exc_tval),
        .o_vld    (w_sel_vld),
        .o_port   (w_sel_port),
        .o_robIdx (w_sel_rob_raw),
        .o_cause  (w_sel_cause),
        .o_tval   (w_sel_tval)
    );

    assign w_sel_rob    = w_sel_rob_raw;
    assign w_squash_rob = i_squash_robIdx;
    assign w_head_rob   = i_head_robIdx;

    assign w_head_match   = i_head_vld && (w_head_rob == r_rec_rob);
    // squash is applied to the record first, then filters the incoming report
    assign w_rec_squashed = i_squash_vld && rob_older(w_squash_rob, r_rec_rob);
    assign w_sel_ok       = w_sel_vld && !(i_squash_vld && rob_older(w_squash_rob, w_sel_rob));

`ifdef TRAP_CTRL_IRQ_EN
    assign w_irq_take  = i_irq_vld && i_head_vld;
    assign w_irq_cause = i_irq_cause;
`else
    assign w_irq_take  = 1'b0;
    assign w_irq_cause = '0;
`endif

    // vectored mode only offsets interrupts; exceptions always land on base
    assign w_vector = {i_mtvec[63:2], 2'b00}
                    + ((r_is_irq && (i_mtvec[1:0] == 2'b01)) ? {46'b0, r_rec_cause, 2'b00} : 64'b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_irq_take)      w_state_next = ST_FLUSH;
                else if (w_sel_ok)   w_state_next = ST_PEND;
            end
            ST_PEND: begin
                if (w_head_match)                     w_state_next = ST_FLUSH;
                else if (w_rec_squashed && !w_sel_ok) w_state_next = ST_IDLE;
            end
            ST_FLUSH:    w_state_next = ST_REDIRECT;
            ST_REDIRECT: if (i_redirect_rdy) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rec_rob   <= '0;
            r_rec_cause <= '0;
            r_rec_tval  <= '0;
            r_mepc      <= '0;
            r_is_irq    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_irq_take) begin
                        r_mepc      <= i_head_pc;
                        r_rec_cause <= w_irq_cause;
                        r_rec_tval  <= '0;
                        r_is_irq    <= 1'b1;
                    end else if (w_sel_ok) begin
                        r_rec_rob   <= w_sel_rob;
                        r_rec_cause <= w_sel_cause;
                        r_rec_tval  <= w_sel_tval;
                        r_is_irq    <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (w_head_match) begin
                        r_mepc <= i_head_pc;
                    end else if (w_sel_ok && (w_rec_squashed || rob_older(w_sel_rob, r_rec_rob))) begin
                        r_rec_rob   <= w_sel_rob;
                        r_rec_cause <= w_sel_cause;
                        r_rec_tval  <= w_sel_tval;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_commit_block = 1'b0;
        o_flush        = 1'b0;
        o_csr_we       = 1'b0;
        o_mepc         = '0;
        o_mcause       = '0;
        o_mtval        = '0;
        o_redirect_vld = 1'b0;
        o_redirect_pc  = '0;
        case (r_state)
            ST_PEND: o_commit_block = w_head_match;
            ST_FLUSH: begin
                o_commit_block = 1'b1;
                o_flush        = 1'b1;
                o_csr_we       = 1'b1;
                o_mepc         = r_mepc;
                o_mcause       = {r_is_irq, 47'b0, r_rec_cause};
                o_mtval        = r_rec_tval;
            end
            ST_REDIRECT: begin
                o_commit_block = 1'b1;
                o_redirect_vld = 1'b1;
                o_redirect_pc  = w_vector;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus a randomized run
// against an age-arithmetic reference model.
module tb_trap_ctrl;

    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0]    exc_vld;
    logic [NR*8-1:0]  exc_rob;
    logic [NR*16-1:0] exc_cause;
    logic [NR*64-1:0] exc_tval;
    logic          squash_vld;
    logic [7:0]    squash_rob;
    logic          head_vld;
    logic [7:0]    head_rob;
    logic [63:0]   head_pc;
    logic [63:0]   mtvec;
`ifdef TRAP_CTRL_IRQ_EN
    logic          irq_vld;
    logic [15:0]   irq_cause;
`endif
    logic          commit_block, flush, csr_we, redirect_vld, redirect_rdy;
    logic [63:0]   mepc, mcause, mtval, redirect_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.NUM_REPORT(NR)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_exc_vld       (exc_vld),
        .i_exc_robIdx    (exc_rob),
        .i_exc_cause     (exc_cause),
        .i_exc_tval      (exc_tval),
        .i_squash_vld    (squash_vld),
        .i_squash_robIdx (squash_rob),
        .i_head_vld      (head_vld),
        .i_head_robIdx   (head_rob),
        .i_head_pc       (head_pc),
        .i_mtvec         (mtvec),
`ifdef TRAP_CTRL_IRQ_EN
        .i_irq_vld       (irq_vld),
        .i_irq_cause     (irq_cause),
`endif
        .o_commit_block  (commit_block),
        .o_flush         (flush),
        .o_csr_we        (csr_we),
        .o_mepc          (mepc),
        .o_mcause        (mcause),
        .o_mtval         (mtval),
        .o_redirect_vld  (redirect_vld),
        .o_redirect_pc   (redirect_pc),
        .i_redirect_rdy  (redirect_rdy)
    );

    function automatic int rob(input int fl, input int idx);
        return fl * 128 + idx;
    endfunction

    // Model age: a is older than b when b lies 1..127 slots ahead on the 256-entry tagged ring.
    function automatic bit older(input int a, input int b);
        int d;
        d = (b - a) & 255;
        return (d >= 1) && (d <= 127);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exc_vld      = '0;
        exc_rob      = '0;
        exc_cause    = '0;
        exc_tval     = '0;
        squash_vld   = 1'b0;
        squash_rob   = '0;
        head_vld     = 1'b0;
        redirect_rdy = 1'b0;
`ifdef TRAP_CTRL_IRQ_EN
        irq_vld      = 1'b0;
        irq_cause    = '0;
`endif
    endtask

    task automatic put_report(input int p, input int lin, input int cause, input logic [63:0] tval);
        exc_vld[p]              = 1'b1;
        exc_rob[p*8 +: 8]       = 8'(lin);
        exc_cause[p*16 +: 16]   = 16'(cause);
        exc_tval[p*64 +: 64]    = tval;
    endtask

    task automatic set_head(input int lin, input logic [63:0] pc);
        head_vld = 1'b1;
        head_rob = 8'(lin);
        head_pc  = pc;
    endtask

    task automatic drain();
        redirect_rdy = 1'b1;
        step();
        redirect_rdy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        head_pc = '0;
        head_rob = '0;
        mtvec = 64'h8000_0000;
        rst = 1'b1;
        set_head(rob(0, 0), 64'h44);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({commit_block, flush, csr_we, redirect_vld} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000", {commit_block, flush, csr_we, redirect_vld});
        end
        checks++;
        if ({mepc, mcause, mtval, redirect_pc} !== 256'b0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {mepc, mcause, mtval, redirect_pc});
        end
        step();
        rst = 1'b0;
        idle_inputs();
        $display("tb: test_reset done");
    endtask

    task automatic test_basic();
        step();
        idle_inputs();
        put_report(1, rob(0, 5), 13, 64'h80);
        set_head(rob(0, 5), 64'h1000);
        @(negedge clk);
        checks++;
        if (commit_block !== 1'b0) begin
            failures++;
            $display("FAIL basic_capture_same_cycle: commit_block=%0b expected 0", commit_block);
        end
        step();
        idle_inputs();
        set_head(rob(0, 5), 64'h1000);
        @(negedge clk);
        checks++;
        if ({commit_block, flush} !== 2'b10) begin
            failures++;
            $display("FAIL basic_pend_match: block,flush=%b expected 10", {commit_block, flush});
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({commit_block, flush, csr_we, redirect_vld} !== 4'b1110) begin
            failures++;
            $display("FAIL basic_flush_ctrl: got %b expected 1110", {commit_block, flush, csr_we, redirect_vld});
        end
        checks++;
        if ({mepc, mcause, mtval} !== {64'h1000, 64'd13, 64'h80}) begin
            failures++;
            $display("FAIL basic_csr: got %h %h %h expected 1000 d 80", mepc, mcause, mtval);
        end
        step();
        @(negedge clk);
        checks++;
        if ({redirect_vld, flush, commit_block} !== 3'b101 || redirect_pc !== 64'h8000_0000) begin
            failures++;
            $display("FAIL basic_redirect: vld,flush,block=%b pc=%h expected 101 pc=80000000",
                     {redirect_vld, flush, commit_block}, redirect_pc);
        end
        drain();
        @(negedge clk);
        checks++;
        if ({redirect_vld, commit_block} !== 2'b00) begin
            failures++;
            $display("FAIL basic_back_idle: vld,block=%b expected 00", {redirect_vld, commit_block});
        end
        $display("tb: test_basic done");
    endtask

    task automatic test_same_cycle();
        step();
        idle_inputs();
        put_report(0, rob(0, 9), 2, 64'h9);
        put_report(2, rob(0, 3), 5, 64'h3);
        step();
        idle_inputs();
        set_head(rob(0, 9), 64'h900);
        @(negedge clk);
        checks++;
        if (commit_block !== 1'b0) begin
            failures++;
            $display("FAIL oldest_not_young: commit_block=%0b expected 0", commit_block);
        end
        step();
        idle_inputs();
        set_head(rob(0, 3), 64'h300);
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({flush, mcause, mtval, mepc} !== {1'b1, 64'd5, 64'h3, 64'h300}) begin
            failures++;
            $display("FAIL oldest_trap: flush=%0b mcause=%h mtval=%h mepc=%h expected 1 5 3 300", flush, mcause, mtval, mepc);
        end
        step();
        drain();
        idle_inputs();
        put_report(0, rob(0, 3), 5, 64'h3);
        step();
        idle_inputs();
        put_report(1, rob(0, 1), 7, 64'h1);
        step();
        idle_inputs();
        set_head(rob(0, 3), 64'h300);
        @(negedge clk);
        checks++;
        if (commit_block !== 1'b0) begin
            failures++;
            $display("FAIL replace_old_head: commit_block=%0b expected 0", commit_block);
        end
        step();
        idle_inputs();
        set_head(rob(0, 1), 64'h100);
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({flush, mcause, mtval} !== {1'b1, 64'd7, 64'h1}) begin
            failures++;
            $display("FAIL replace_trap: flush=%0b mcause=%h mtval=%h expected 1 7 1", flush, mcause, mtval);
        end
        step();
        drain();
        idle_inputs();
        put_report(1, rob(0, 4), 4, 64'h44);
        put_report(2, rob(0, 4), 6, 64'h66);
        step();
        idle_inputs();
        put_report(0, rob(0, 4), 9, 64'h99);
        step();
        idle_inputs();
        set_head(rob(0, 4), 64'h400);
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({flush, mcause, mtval} !== {1'b1, 64'd4, 64'h44}) begin
            failures++;
            $display("FAIL tie_break: flush=%0b mcause=%h mtval=%h expected 1 4 44", flush, mcause, mtval);
        end
        step();
        drain();
        $display("tb: test_same_cycle done");
    endtask

    task automatic test_wrap();
        idle_inputs();
        put_report(0, rob(0, 127), 4, 64'h127);
        step();
        idle_inputs();
        put_report(1, rob(1, 0), 6, 64'h100);
        step();
        idle_inputs();
        set_head(rob(1, 0), 64'h3000);
        @(negedge clk);
        checks++;
        if (commit_block !== 1'b0) begin
            failures++;
            $display("FAIL wrap_young_kept_out: commit_block=%0b expected 0", commit_block);
        end
        step();
        idle_inputs();
        set_head(rob(0, 127), 64'h2F00);
        @(negedge clk);
        checks++;
        if (commit_block !== 1'b1) begin
            failures++;
            $display("FAIL wrap_head_match: commit_block=%0b expected 1", commit_block);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({flush, mcause, mtval, mepc} !== {1'b1, 64'd4, 64'h127, 64'h2F00}) begin
            failures++;
            $display("FAIL wrap_trap: flush=%0b mcause=%h mtval=%h mepc=%h expected 1 4 127 2f00", flush, mcause, mtval, mepc);
        end
        step();
        drain();
        $display("tb: test_wrap done");
    endtask

    task automatic test_squash();
        idle_inputs();
        put_report(2, rob(0, 20), 5, 64'h20);
        step();
        idle_inputs();
        squash_vld = 1'b1;
        squash_rob = 8'(rob(0, 10));
        step();
        idle_inputs();
        set_head(rob(0, 20), 64'h4000);
        @(negedge clk);
        checks++;
        if (commit_block !== 1'b0) begin
            failures++;
            $display("FAIL squash_drop: commit_block=%0b expected 0", commit_block);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (flush !== 1'b0) begin
            failures++;
            $display("FAIL squash_no_flush: flush=%0b expected 0", flush);
        end
        step();
        idle_inputs();
        put_report(0, rob(0, 20), 5, 64'h20);
        step();
        idle_inputs();
        squash_vld = 1'b1;
        squash_rob = 8'(rob(0, 10));
        put_report(1, rob(0, 8), 2, 64'h8);
        step();
        idle_inputs();
        set_head(rob(0, 8), 64'h5000);
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({flush, mcause, mtval, mepc} !== {1'b1, 64'd2, 64'h8, 64'h5000}) begin
            failures++;
            $display("FAIL squash_same_cycle_report: flush=%0b mcause=%h mtval=%h mepc=%h expected 1 2 8 5000", flush, mcause, mtval, mepc);
        end
        step();
        drain();
        idle_inputs();
        put_report(2, rob(0, 5), 1, 64'h5);
        step();
        idle_inputs();
        squash_vld = 1'b1;
        squash_rob = 8'(rob(0, 5));
        step();
        idle_inputs();
        set_head(rob(0, 5), 64'h5500);
        @(negedge clk);
        checks++;
        if (commit_block !== 1'b1) begin
            failures++;
            $display("FAIL squash_equal_kept: commit_block=%0b expected 1", commit_block);
        end
        step();
        idle_inputs();
        step();
        drain();
        $display("tb: test_squash done");
    endtask

    task automatic test_redirect_stall();
        idle_inputs();
        mtvec = 64'h8000_0003;
        put_report(0, rob(0, 40), 1, 64'h40);
        step();
        idle_inputs();
        set_head(rob(0, 40), 64'h6000);
        step();
        idle_inputs();
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({redirect_vld, commit_block} !== 2'b11 || redirect_pc !== 64'h8000_0000) begin
                failures++;
                $display("FAIL stall_hold_%0d: vld,block=%b pc=%h expected 11 80000000", k, {redirect_vld, commit_block}, redirect_pc);
            end
            step();
        end
        rst = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({commit_block, flush, csr_we, redirect_vld, mepc, mcause, mtval, redirect_pc} !== 260'b0) begin
            failures++;
            $display("FAIL reset_in_redirect: got vld=%0b block=%0b pc=%h expected all 0", redirect_vld, commit_block, redirect_pc);
        end
        rst = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (redirect_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_redirect_dropped: redirect_vld=%0b expected 0", redirect_vld);
        end
        $display("tb: test_redirect_stall done");
    endtask

`ifdef TRAP_CTRL_IRQ_EN
    task automatic test_irq();
        step();
        idle_inputs();
        mtvec     = 64'h8000_0001;
        irq_vld   = 1'b1;
        irq_cause = 16'd7;
        set_head(rob(0, 2), 64'h2000);
        put_report(0, rob(0, 2), 3, 64'h33);
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({flush, mcause, mtval, mepc} !== {1'b1, 64'h8000_0000_0000_0007, 64'h0, 64'h2000}) begin
            failures++;
            $display("FAIL irq_csr: flush=%0b mcause=%h mtval=%h mepc=%h", flush, mcause, mtval, mepc);
        end
        step();
        @(negedge clk);
        checks++;
        if (redirect_pc !== 64'h8000_001C) begin
            failures++;
            $display("FAIL irq_vector: pc=%h expected 8000001c", redirect_pc);
        end
        drain();
        idle_inputs();
        set_head(rob(0, 2), 64'h2000);
        @(negedge clk);
        checks++;
        if (commit_block !== 1'b0) begin
            failures++;
            $display("FAIL irq_exc_lost: commit_block=%0b expected 0", commit_block);
        end
        $display("tb: test_irq done");
    endtask
`endif

    task automatic test_random();
        bit           m_have;
        int           m_rec, m_cause, base, best, hl, sl;
        logic [63:0]  m_tval, m_pc;
        int           m_trap;
        bit           e_block, e_flush, e_redir;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_have = 0; m_rec = 0; m_cause = 0; m_tval = '0; m_pc = '0; m_trap = -1;
        base = $urandom_range(0, 255);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            idle_inputs();
            base = (base + $urandom_range(0, 3)) & 255;
            for (int p = 0; p < NR; p++)
                if ($urandom_range(0, 3) == 0)
                    put_report(p, (base + $urandom_range(0, 15)) & 255, $urandom_range(0, 65535), {$urandom, $urandom});
            if ($urandom_range(0, 5) == 0) begin
                squash_vld = 1'b1;
                squash_rob = 8'((base + $urandom_range(0, 15)) & 255);
            end
            if ($urandom_range(0, 2) != 0) begin
                hl = (m_have && $urandom_range(0, 1) == 1) ? m_rec : ((base + $urandom_range(0, 15)) & 255);
                set_head(hl, {$urandom, $urandom});
            end
            redirect_rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) mtvec = {$urandom, $urandom};
            if (m_trap < 0 && m_have && head_vld && int'(head_rob) == m_rec) begin
                exc_vld    = '0;
                squash_vld = 1'b0;
            end
            @(negedge clk);
            e_flush = (m_trap == 0);
            e_redir = (m_trap >= 1);
            e_block = e_flush || e_redir || (m_trap < 0 && m_have && head_vld && int'(head_rob) == m_rec);
            checks++;
            if ({commit_block, flush, csr_we, redirect_vld} !== {e_block, e_flush, e_flush, e_redir}) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d: got %b expected %b", cyc,
                         {commit_block, flush, csr_we, redirect_vld}, {e_block, e_flush, e_flush, e_redir});
            end
            if (e_flush) begin
                checks++;
                if ({mepc, mcause, mtval} !== {m_pc, 48'b0, 16'(m_cause), m_tval}) begin
                    failures++;
                    $display("FAIL rand_csr cyc=%0d: got %h %h %h expected %h %h %h", cyc, mepc, mcause, mtval, m_pc, m_cause, m_tval);
                end
            end
            if (e_redir) begin
                checks++;
                if (redirect_pc !== {mtvec[63:2], 2'b00}) begin
                    failures++;
                    $display("FAIL rand_vector cyc=%0d: got %h expected %h", cyc, redirect_pc, {mtvec[63:2], 2'b00});
                end
            end
            if (m_trap == 0) begin
                m_trap = 1;
            end else if (m_trap >= 1) begin
                if (redirect_rdy) begin
                    m_trap = -1;
                    m_have = 0;
                end
            end else if (m_have && head_vld && int'(head_rob) == m_rec) begin
                m_trap = 0;
                m_pc   = head_pc;
            end else begin
                sl = int'(squash_rob);
                if (m_have && squash_vld && older(sl, m_rec)) m_have = 0;
                best = -1;
                for (int p = 0; p < NR; p++)
                    if (exc_vld[p] && (best < 0 || older(int'(exc_rob[p*8 +: 8]), int'(exc_rob[best*8 +: 8]))))
                        best = p;
                if (best >= 0 && !(squash_vld && older(sl, int'(exc_rob[best*8 +: 8])))) begin
                    if (!m_have || older(int'(exc_rob[best*8 +: 8]), m_rec)) begin
                        m_have  = 1;
                        m_rec   = int'(exc_rob[best*8 +: 8]);
                        m_cause = int'(exc_cause[best*16 +: 16]);
                        m_tval  = exc_tval[best*64 +: 64];
                    end
                end
            end
        end
        $display("tb: test_random done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_wrap();
        test_squash();
        test_redirect_stall();
`ifdef TRAP_CTRL_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
